cfu_mac_driver: RTL and testbench

CFU_MAC_DRIVER -- requirements
Module: cfu_mac_driver

---
 rtl/cfu_mac_driver.sv | 166 ++++++++++++++++
 tb/tb_cfu_mac_driver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_mac_driver.sv
// Drives a CFU through one int8 MAC job: program input offset, then len operand pairs.
// Optional response timeout with sticky error flag: define CFU_DRV_TIMEOUT_EN.
module cfu_mac_driver #(
    parameter int LEN_W   = 16,
    parameter int TMO_CYC = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      input_offset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data_0,
    input  logic [31:0]      in_data_1,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [9:0]       cmd_payload_function_id,
    output logic [31:0]      cmd_payload_inputs_0,
    output logic [31:0]      cmd_payload_inputs_1,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [31:0]      rsp_payload_outputs_0,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic             error
);

    localparam logic [9:0] FUNC_MAC = 10'h000;
    localparam logic [9:0] FUNC_OFF = 10'h008;

    if (TMO_CYC < 1) begin : g_bad_tmo
        $error("TMO_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE, CMD_OFF, RSP_OFF, LOAD, CMD_MAC, RSP_MAC, DONE
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [9:0]       func_q, func_d;
    logic [31:0]      op0_q, op0_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      result_q, result_d;
    logic             tmo_hit;

    assign cnt_inc = cnt_q + LEN_W'(1);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        func_d   = func_q;
        op0_d    = op0_q;
        op1_d    = op1_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: if (start) begin
                len_d    = len;
                cnt_d    = '0;
                result_d = '0;
                func_d   = FUNC_OFF;
                op0_d    = {16'h0, input_offset};
                op1_d    = '0;
                state_d  = CMD_OFF;
            end
            CMD_OFF: if (cmd_ready) state_d = RSP_OFF;
            // The offset command's response carries no data worth keeping.
            RSP_OFF: if (rsp_valid) state_d = (len_q == '0) ? DONE : LOAD;
            LOAD: if (in_valid) begin
                func_d  = FUNC_MAC;
                op0_d   = in_data_0;
                op1_d   = in_data_1;
                state_d = CMD_MAC;
            end
            CMD_MAC: if (cmd_ready) state_d = RSP_MAC;
            RSP_MAC: if (rsp_valid) begin
                result_d = rsp_payload_outputs_0;
                cnt_d    = cnt_inc;
                state_d  = (cnt_inc == len_q) ? DONE : LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            func_q   <= '0;
            op0_q    <= '0;
            op1_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            func_q   <= func_d;
            op0_q    <= op0_d;
            op1_q    <= op1_d;
            result_q <= result_d;
        end
    end

`ifdef CFU_DRV_TIMEOUT_EN
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             error_q, error_d;
    logic             rsp_wait;

    assign rsp_wait = ((state_q == RSP_OFF) || (state_q == RSP_MAC)) && !rsp_valid;

    // The wait counter restarts whenever a response arrives or the FSM leaves a response state.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        error_d = error_q;
        if ((state_q == IDLE) && start) error_d = 1'b0;
        if (rsp_wait) begin
            if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                tmo_hit = 1'b1;
                error_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q   <= '0;
            error_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign tmo_hit = 1'b0;
    assign error   = 1'b0;
`endif

    // Handshake outputs are pure decodes of the state register, independent of cmd_ready.
    assign cmd_valid = (state_q == CMD_OFF) || (state_q == CMD_MAC);
    assign rsp_ready = (state_q == RSP_OFF) || (state_q == RSP_MAC);
    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;

    assign cmd_payload_function_id = func_q;
    assign cmd_payload_inputs_0    = op0_q;
    assign cmd_payload_inputs_1    = op1_q;

endmodule

// File: tb/tb_cfu_mac_driver.sv
// Directed bench for cfu_mac_driver with a behavioural CFU responder.
// Define CFU_DRV_TIMEOUT_EN for both files to include the timeout scenario.
module tb_cfu_mac_driver;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [15:0]      input_offset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data_0;
    logic [31:0]      in_data_1;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [9:0]       cmd_payload_function_id;
    logic [31:0]      cmd_payload_inputs_0;
    logic [31:0]      cmd_payload_inputs_1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_payload_outputs_0;
    logic             busy;
    logic             done;
    logic [31:0]      result;
    logic             error;

    always #5 clk = ~clk;

    cfu_mac_driver #(.LEN_W(LEN_W), .TMO_CYC(255)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .len                     (len),
        .input_offset            (input_offset),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_data_0               (in_data_0),
        .in_data_1               (in_data_1),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .busy                    (busy),
        .done                    (done),
        .result                  (result),
        .error                   (error)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // CFU model: offset command clears the accumulator, MAC adds sum((a_i+offset)*w_i).
    function automatic logic signed [31:0] mac4(input logic [31:0] a, input logic [31:0] w,
                                               input logic signed [15:0] off);
        logic signed [7:0]  ai;
        logic signed [7:0]  wi;
        logic signed [31:0] s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            ai = a[8*i +: 8];
            wi = w[8*i +: 8];
            s  = s + (ai + off) * wi;
        end
        return s;
    endfunction

    int  stall_cycles = 0;
    bit  withhold     = 0;
    int  n_off = 0, n_mac = 0, n_other = 0;

    initial begin : responder
        logic signed [31:0] acc_m;
        logic signed [15:0] off_m;
        logic [31:0]        rsp_m;
        logic               cv_s, rr_s;
        logic [9:0]         f_s;
        logic [31:0]        i0_s, i1_s;
        int                 stall_cnt;
        bit                 pending;
        acc_m = 0; off_m = 0; rsp_m = 0; cv_s = 0; rr_s = 0;
        f_s = 0; i0_s = 0; i1_s = 0; stall_cnt = 0; pending = 0;
        cmd_ready = 0; rsp_valid = 0; rsp_payload_outputs_0 = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                cmd_ready = 0; rsp_valid = 0; pending = 0; stall_cnt = 0;
            end else begin
                if (rsp_valid && rr_s) begin
                    rsp_valid = 0;
                    pending   = 0;
                end
                if (cmd_ready && cv_s) begin
                    cmd_ready = 0;
                    stall_cnt = 0;
                    if (f_s == 10'h008) begin
                        n_off++; off_m = i0_s[15:0]; acc_m = 0; rsp_m = 0;
                    end else if (f_s == 10'h000) begin
                        n_mac++; acc_m = acc_m + mac4(i0_s, i1_s, off_m); rsp_m = acc_m;
                    end else begin
                        n_other++;
                    end
                    pending = 1;
                end else if (cmd_valid && cv_s) begin
                    check("stall_func", {22'h0, cmd_payload_function_id}, {22'h0, f_s});
                    check("stall_in0", cmd_payload_inputs_0, i0_s);
                    check("stall_in1", cmd_payload_inputs_1, i1_s);
                end
                if (pending && !withhold) begin
                    rsp_valid = 1;
                    rsp_payload_outputs_0 = rsp_m;
                end
                if (cmd_valid && !cmd_ready) begin
                    if (stall_cnt >= stall_cycles) cmd_ready = 1;
                    else stall_cnt++;
                end
            end
            cv_s = cmd_valid; rr_s = rsp_ready;
            f_s  = cmd_payload_function_id;
            i0_s = cmd_payload_inputs_0; i1_s = cmd_payload_inputs_1;
        end
    end

    task automatic pulse_start(input logic [LEN_W-1:0] l, input logic [15:0] off);
        @(negedge clk);
        start = 1; len = l; input_offset = off;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run_job(input string tag, input logic [LEN_W-1:0] l, input logic [15:0] off,
                           input logic [31:0] a, input logic [31:0] w, input logic [31:0] exp_res,
                           input int exp_mac);
        int dones, ins, cyc, off0, mac0, oth0;
        logic [31:0] res;
        dones = 0; ins = 0; cyc = 0; res = 'x;
        off0 = n_off; mac0 = n_mac; oth0 = n_other;
        in_data_0 = a; in_data_1 = w;
        pulse_start(l, off);
        check({tag, "_cmd_valid_after_start"}, cmd_valid, 1);
        check({tag, "_error_clear"}, error, 0);
        while (busy && cyc < 3000) begin
            if (done) begin dones++; res = result; end
            if (in_ready) ins++;
            in_valid = in_ready;
            @(negedge clk);
            cyc++;
        end
        in_valid = 0;
        check({tag, "_finished"}, cyc < 3000, 1);
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_result_at_done"}, res, exp_res);
        check({tag, "_in_accepts"}, ins, exp_mac);
        repeat (2) @(negedge clk);
        check({tag, "_off_cmds"}, n_off - off0, 1);
        check({tag, "_mac_cmds"}, n_mac - mac0, exp_mac);
        check({tag, "_bad_cmds"}, n_other - oth0, 0);
        check({tag, "_result_hold"}, result, exp_res);
        check({tag, "_idle_done"}, done, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int ins, cyc, dones, rr_cyc;
        reset = 1; start = 0; len = 0; input_offset = 0;
        in_valid = 0; in_data_0 = 0; in_data_1 = 0;
        repeat (3) @(negedge clk);
        reset = 0;

        check("rst_busy", busy, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_rsp_ready", rsp_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_result", result, 0);
        check("rst_func", {22'h0, cmd_payload_function_id}, 0);
        check("rst_in0", cmd_payload_inputs_0, 0);

        // (1+128)*2*4 = 1032
        run_job("len1", 16'd1, 16'd128, 32'h01010101, 32'h02020202, 32'd1032, 1);
        // Result must drop from 1032 to 0 for an empty job
        run_job("len0", 16'd0, 16'd5, 32'h01010101, 32'h02020202, 32'd0, 0);
        // (-1)*1*4 per pair, three pairs, with each command stalled 4 cycles
        stall_cycles = 4;
        run_job("stall", 16'd3, 16'd0, 32'hFFFFFFFF, 32'h01010101, 32'hFFFFFFF4, 3);
        stall_cycles = 0;

        // Abandon a len-4 job while it waits for the second MAC response
        in_data_0 = 32'h01010101; in_data_1 = 32'h01010101;
        pulse_start(16'd4, 16'd0);
        ins = 0; cyc = 0;
        while (!(ins >= 2 && rsp_ready) && cyc < 200) begin
            if (in_ready) ins++;
            in_valid = in_ready;
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_rsp_mac", cyc < 200, 1);
        reset = 1; in_valid = 0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_cmd_valid", cmd_valid, 0);
        check("abort_rsp_ready", rsp_ready, 0);
        check("abort_result", result, 0);
        reset = 0;
        dones = 0;
        repeat (10) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);
        // Bytes (2,10,-128,127) and (5,3,-1,1), offset -1: 5+27+129+126 = 287 per pair
        run_job("after_abort", 16'd2, 16'hFFFF, 32'h7F800A02, 32'h01FF0305, 32'd574, 2);

`ifdef CFU_DRV_TIMEOUT_EN
        withhold = 1;
        pulse_start(16'd1, 16'd0);
        cyc = 0; rr_cyc = 0; dones = 0;
        while (busy && cyc < 1000) begin
            if (rsp_ready) rr_cyc++;
            if (done) dones++;
            @(negedge clk);
            cyc++;
        end
        check("tmo_ended", cyc < 1000, 1);
        check("tmo_wait_cycles", rr_cyc, 255);
        check("tmo_error", error, 1);
        check("tmo_busy", busy, 0);
        check("tmo_no_done", dones, 0);
        repeat (3) @(negedge clk);
        check("tmo_error_sticky", error, 1);
        withhold = 0;
        run_job("after_tmo", 16'd1, 16'd128, 32'h01010101, 32'h02020202, 32'd1032, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
